qsys_10g_eth_10g_mac_rx_st_timing_adapter_fifo: RTL and testbench

//  Avalon-ST timing adapter on the 10G MAC RX streaming path: ready-latency-0 source (valid/ready) to ready-latency-1 sink.

---
 rtl/eth_10g_st_pkg.sv | 14 +
 rtl/eth_10g_st_fifo_mem.sv | 28 ++
 rtl/qsys_10g_eth_10g_mac_rx_st_timing_adapter_fifo.sv | 91 +++++++++
 tb/tb_qsys_10g_eth_10g_mac_rx_st_timing_adapter_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_10g_st_pkg.sv
// Shared definitions for the 10G Ethernet Avalon-ST helpers: default beat width,
// packed beat type and the fill-level width rule.
package eth_10g_st_pkg;

    localparam int ST_DATA_W = 72;

    typedef logic [ST_DATA_W-1:0] st_beat_t;

    // Fill level counts 0..depth inclusive, so it needs one more code than the pointers.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/eth_10g_st_fifo_mem.sv
// Storage array for the RX timing adapter: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module eth_10g_st_fifo_mem
    import eth_10g_st_pkg::*;
#(
    parameter int DATA_W = ST_DATA_W,
    parameter int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/qsys_10g_eth_10g_mac_rx_st_timing_adapter_fifo.sv
// RX Avalon-ST timing adapter: ready-latency-0 source to ready-latency-1 sink via a small FIFO.
// Optional cut-through on an empty FIFO when RX_TA_BYPASS_EN is defined.
module qsys_10g_eth_10g_mac_rx_st_timing_adapter_fifo
    import eth_10g_st_pkg::*;
#(
    parameter int DATA_W = ST_DATA_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  fill_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic              ready_d1_reg;
    logic              push;
    logic              pop;
    logic              bypass;
    logic [DATA_W-1:0] rd_data;

    eth_10g_st_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (in_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    // Full is decoded from the registered count, so a pop in the same cycle cannot
    // open a slot for the upstream; this keeps in_ready free of out_ready paths.
    assign in_ready = (count_reg != FULL_CNT);
    assign pop      = ready_d1_reg && (count_reg != '0);

`ifdef RX_TA_BYPASS_EN
    assign bypass    = (count_reg == '0) && ready_d1_reg && in_valid;
    assign out_valid = pop || bypass;
    assign out_data  = bypass ? in_data : rd_data;
`else
    assign bypass    = 1'b0;
    assign out_valid = pop;
    assign out_data  = rd_data;
`endif

    assign push       = in_valid && in_ready && !bypass;
    assign fill_level = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ready_d1_reg <= 1'b0;
        end else begin
            ready_d1_reg <= out_ready;
            count_reg    <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_qsys_10g_eth_10g_mac_rx_st_timing_adapter_fifo.sv
// Scoreboard bench for the RX timing adapter: accepted input beats are queued,
// an output monitor pops and compares them and checks the ready-latency-1 rule.
module tb_qsys_10g_eth_10g_mac_rx_st_timing_adapter_fifo;
    import eth_10g_st_pkg::*;

    localparam int DATA_W = 72;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
`ifdef RX_TA_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  fill_level;

    int       checks = 0;
    int       errors = 0;
    st_beat_t exp_q[$];
    logic     ready_prev = 1'b0;

    qsys_10g_eth_10g_mac_rx_st_timing_adapter_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Upstream acceptance: every handshaken beat becomes an expected output.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    // out_ready as seen by the DUT at the last rising edge.
    initial begin
        forever begin
            @(posedge clk);
            ready_prev = reset_n ? out_ready : 1'b0;
        end
    end

    // Output monitor: runs after the acceptance capture in the same half-cycle.
    initial begin
        st_beat_t exp_beat;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && out_valid) begin
                checks++;
                if (!ready_prev) begin
                    errors++;
                    $display("FAIL rl1_rule: out_valid=1 with previous out_ready=0");
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h required no beat", out_data);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat_data", out_data, exp_beat);
                    $display("beat out 0x%0h (expected 0x%0h) pending=%0d", out_data, exp_beat, exp_q.size());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fill_level != '0) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d fill=%0d required 0", name, exp_q.size(), fill_level);
        end
    endtask

    initial begin
        int k;
        int cyc;
        st_beat_t beat;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        check("reset_out_valid", DATA_W'(out_valid), DATA_W'(0));
        check("reset_in_ready", DATA_W'(in_ready), DATA_W'(1));
        check("reset_fill", DATA_W'(fill_level), DATA_W'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        // Streaming with out_ready high: data 0..7
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            @(negedge clk);
            check("stream_in_ready", DATA_W'(in_ready), DATA_W'(1));
            check("stream_out_valid", DATA_W'(out_valid), DATA_W'((i == 0) ? BYPASS : 1'b1));
            step();
        end
        in_valid = 1'b0;
        drain("stream");

        // Backpressure: out_ready low, offer 6 beats
        out_ready = 1'b0;
        repeat (2) step();
        k = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (k < 6);
            in_data  = DATA_W'(32'h100 + k);
            @(negedge clk);
            if (in_valid && in_ready) k++;
            step();
        end
        check("bp_accepted", DATA_W'(k), DATA_W'(4));
        @(negedge clk);
        check("bp_in_ready", DATA_W'(in_ready), DATA_W'(0));
        check("bp_fill", DATA_W'(fill_level), DATA_W'(4));
        check("bp_out_valid", DATA_W'(out_valid), DATA_W'(0));
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid_d0", DATA_W'(out_valid), DATA_W'(0));
        step();
        @(negedge clk);
        check("release_out_valid_d1", DATA_W'(out_valid), DATA_W'(1));
        check("full_pushpop_in_ready", DATA_W'(in_ready), DATA_W'(0));
        step();
        @(negedge clk);
        check("after_pop_in_ready", DATA_W'(in_ready), DATA_W'(1));
        check("after_pop_fill", DATA_W'(fill_level), DATA_W'(3));
        step();
        in_data = DATA_W'(32'h105);
        step();
        in_valid = 1'b0;
        drain("backpressure");

        // out_ready toggling 1,0,1,0 with 16 random beats
        k    = 0;
        cyc  = 0;
        beat = DATA_W'({$urandom(), $urandom(), $urandom()});
        while (k < 16 && cyc < 200) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = 1'b1;
            in_data   = beat;
            @(negedge clk);
            if (in_ready) begin
                k++;
                beat = DATA_W'({$urandom(), $urandom(), $urandom()});
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("toggle_accepted", DATA_W'(k), DATA_W'(16));
        drain("toggle");

        // Asynchronous reset with three buffered beats
        out_ready = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(32'h200 + i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        #1;
        check("prereset_fill", DATA_W'(fill_level), DATA_W'(3));
        check("prereset_out_valid", DATA_W'(out_valid), DATA_W'(1));
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_out_valid", DATA_W'(out_valid), DATA_W'(0));
        check("async_reset_fill", DATA_W'(fill_level), DATA_W'(0));
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_out_valid", DATA_W'(out_valid), DATA_W'(0));
            check("post_reset_fill", DATA_W'(fill_level), DATA_W'(0));
            step();
        end

`ifdef RX_TA_BYPASS_EN
        // Cut-through on an empty FIFO
        out_ready = 1'b1;
        repeat (2) step();
        in_valid = 1'b1;
        in_data  = DATA_W'(8'hAB);
        @(negedge clk);
        check("bypass_out_valid", DATA_W'(out_valid), DATA_W'(1));
        check("bypass_out_data", out_data, DATA_W'(8'hAB));
        check("bypass_fill", DATA_W'(fill_level), DATA_W'(0));
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bypass_fill_after", DATA_W'(fill_level), DATA_W'(0));
        step();
`endif

        repeat (3) step();
        check("scoreboard_empty", DATA_W'(exp_q.size()), DATA_W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
